tlul_sram_device: RTL and testbench

TLUL_SRAM_DEVICE -- requirements
Module: tlul_sram_device

---
 rtl/tlul_pkg.sv | 37 +++
 rtl/tlul_rsp_fifo.sv | 42 ++++
 rtl/tlul_sram_device.sv | 99 +++++++++
 tb/tb_tlul_sram_device.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs and opcode enums shared by host and device
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_rsp_fifo.sv
// tlul_rsp_fifo: in-order response queue with separate full and empty flags
module tlul_rsp_fifo #(
  parameter int Depth = 4,
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid,
  input  logic [Width-1:0] wdata,
  input  logic             rready,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int Pw = Depth > 1 ? $clog2(Depth) : 1;
  localparam int Cw = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [Pw-1:0] wptr, rptr;
  logic [Cw-1:0] count;
  logic push, pop;
  assign full  = count == Cw'(Depth);
  assign empty = count == '0;
  assign push  = wvalid & ~full;
  assign pop   = rready & ~empty;
  assign rdata = mem[rptr];
  // pointer and occupancy bookkeeping, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == Pw'(Depth - 1)) ? '0 : wptr + Pw'(1);
      if (pop) rptr <= (rptr == Pw'(Depth - 1)) ? '0 : rptr + Pw'(1);
      count <= count + Cw'(push) - Cw'(pop);
    end
  end
  // storage needs no reset; only entries behind valid pointers are read
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/tlul_sram_device.sv
// tlul_sram_device: TL-UL device adapter driving a single-port SRAM with 1-cycle read latency
module tlul_sram_device
  import tlul_pkg::*;
#(
  parameter int SramAw      = 12,
  parameter int Outstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);
  typedef struct packed {
    logic        get;
    logic [7:0]  source;
    logic [1:0]  size;
    logic        err;
    logic [31:0] data;
  } rsp_t;
  localparam int Cw = $clog2(Outstanding + 1);
  logic [Cw-1:0] cnt;
  logic a_ready, a_hs, d_hs, a_err, op_ok, align_ok, addr_ok;
  logic p_valid, p_get, p_err;
  logic [7:0] p_source;
  logic [1:0] p_size;
  rsp_t wr_rsp, rd_rsp;
  logic full, empty;
  logic unused_param;
  assign unused_param = ^{tl_i.a_param, full};
  assign a_ready = cnt < Cw'(Outstanding);
  assign a_hs    = tl_i.a_valid & a_ready;
  assign d_hs    = ~empty & tl_i.d_ready;
  // request decode: error screening and SRAM strobes in the accept cycle
  always_comb begin
    op_ok    = tl_i.a_opcode inside {Get, PutFullData, PutPartialData};
    align_ok = (tl_i.a_size == 2'd0) | (tl_i.a_size == 2'd1 & ~tl_i.a_address[0]) |
               (tl_i.a_size == 2'd2 & tl_i.a_address[1:0] == 2'b00);
    addr_ok  = tl_i.a_address[31:SramAw+2] == '0;
    a_err    = ~op_ok | ~align_ok | ~addr_ok;
    req_o    = a_hs & ~a_err;
    we_o     = req_o & (tl_i.a_opcode != Get);
    addr_o   = tl_i.a_address[SramAw+1:2];
    wdata_o  = tl_i.a_data;
    wmask_o  = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}}, {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
  end
  // outstanding count covers the pipeline stage plus everything queued for D
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt <= '0;
    else cnt <= cnt + Cw'(a_hs) - Cw'(d_hs);
  end
  // one-stage pipeline aligning request metadata with SRAM read data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p_valid  <= 1'b0;
      p_get    <= 1'b0;
      p_err    <= 1'b0;
      p_source <= '0;
      p_size   <= '0;
    end else begin
      p_valid  <= a_hs;
      p_get    <= tl_i.a_opcode == Get;
      p_err    <= a_err;
      p_source <= tl_i.a_source;
      p_size   <= tl_i.a_size;
    end
  end
  // response entry: read data for good Gets, all-ones for failed Gets, zero for writes
  always_comb begin
    wr_rsp = '{get: p_get, source: p_source, size: p_size, err: p_err,
               data: p_get ? (p_err ? 32'hFFFF_FFFF : rdata_i) : 32'h0};
  end
  tlul_rsp_fifo #(.Depth(Outstanding), .Width($bits(rsp_t))) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .wvalid(p_valid),
    .wdata (wr_rsp),
    .rready(tl_i.d_ready),
    .rdata (rd_rsp),
    .full  (full),
    .empty (empty)
  );
  // D channel presents the FIFO head, so it holds while stalled
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = ~empty;
    tl_o.d_opcode = rd_rsp.get ? AccessAckData : AccessAck;
    tl_o.d_size   = rd_rsp.size;
    tl_o.d_source = rd_rsp.source;
    tl_o.d_data   = rd_rsp.data;
    tl_o.d_error  = rd_rsp.err;
    tl_o.a_ready  = a_ready;
  end
endmodule

// File: tb/tb_tlul_sram_device.sv
// tb_tlul_sram_device: directed scenarios with a response scoreboard and an SRAM model
module tb_tlul_sram_device;
  import tlul_pkg::*;
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  size;
    logic        err;
    logic [31:0] data;
  } exp_t;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic req_o, we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o, wmask_o, rdata_i;
  logic [31:0] mem [16];
  exp_t sb[$];
  int hs_cyc[$];
  int cyc = 0, checks = 0, fails = 0;
  exp_t e;
  logic [63:0] snap;

  tlul_sram_device #(.SramAw(12), .Outstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o), .req_o(req_o), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // SRAM model: one-cycle read latency, byte-masked writes
  always @(posedge clk_i) begin
    if (req_o && we_o) mem[addr_o[3:0]] <= (mem[addr_o[3:0]] & ~wmask_o) | (wdata_o & wmask_o);
    else if (req_o) rdata_i <= mem[addr_o[3:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every D handshake is matched against the oldest expected response
  always @(negedge clk_i) begin
    if (rst_ni && tl_o.d_valid && tl_i.d_ready) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got source %h with empty scoreboard", tl_o.d_source);
      end else begin
        e = sb.pop_front();
        chk("d_opcode", 64'(tl_o.d_opcode), 64'(e.op));
        chk("d_source", 64'(tl_o.d_source), 64'(e.src));
        chk("d_size", 64'(tl_o.d_size), 64'(e.size));
        chk("d_error", 64'(tl_o.d_error), 64'(e.err));
        chk("d_data", 64'(tl_o.d_data), 64'(e.data));
        chk("d_param_sink", 64'({tl_o.d_param, tl_o.d_sink}), 64'(0));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                      input bit bad, input logic [31:0] wm, input logic [31:0] rd);
    int w = 0;
    tl_i.a_valid = 1'b1;
    tl_i.a_opcode = tl_a_op_e'(op);
    tl_i.a_address = addr;
    tl_i.a_size = size;
    tl_i.a_mask = mask;
    tl_i.a_data = data;
    tl_i.a_source = src;
    @(negedge clk_i);
    while (!tl_o.a_ready && w < 50) begin
      w++;
      @(negedge clk_i);
    end
    if (!tl_o.a_ready) chk("a_ready_timeout", 64'(tl_o.a_ready), 64'(1));
    else begin
      chk("req_o", 64'(req_o), 64'(!bad));
      if (!bad) begin
        chk("addr_o", 64'(addr_o), 64'(addr[13:2]));
        chk("we_o", 64'(we_o), 64'(op != 3'h4));
        if (op != 3'h4) chk("wmask_o", 64'(wmask_o), 64'(wm));
        if (op != 3'h4) chk("wdata_o", 64'(wdata_o), 64'(data));
      end
      sb.push_back('{op: (op == 3'h4) ? 3'h1 : 3'h0, src: src, size: size, err: bad,
                     data: (op == 3'h4) ? (bad ? 32'hFFFF_FFFF : rd) : 32'h0});
    end
    @(posedge clk_i);
    #1 tl_i.a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    @(negedge clk_i);
    while (sb.size() != 0 && w < 50) begin
      w++;
      @(negedge clk_i);
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int w;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_a_ready", 64'(tl_o.a_ready), 64'(1));
    chk("rst_d_valid", 64'(tl_o.d_valid), 64'(0));
    chk("rst_req_we", 64'({req_o, we_o}), 64'(0));
    @(posedge clk_i);
    #1;
    // single Get: response appears two cycles after the accept
    send(3'h4, 32'h10, 2'd2, 4'hF, 0, 8'h01, 0, 0, 32'hDEAD_BEEF);
    @(negedge clk_i);
    chk("s1_dvalid_n1", 64'(tl_o.d_valid), 64'(0));
    @(negedge clk_i);
    chk("s1_dvalid_n2", 64'(tl_o.d_valid), 64'(1));
    wait_drain();
    // partial write then read back the merged word
    send(3'h1, 32'h8, 2'd2, 4'b0110, 32'h1122_3344, 8'h02, 0, 32'h00FF_FF00, 0);
    send(3'h4, 32'h8, 2'd2, 4'hF, 0, 8'h03, 0, 0, 32'hA022_3302);
    // error cases and boundary sizes
    send(3'h4, 32'h2, 2'd2, 4'hF, 0, 8'h04, 1, 0, 0);
    send(3'h4, 32'h0001_0000, 2'd2, 4'hF, 0, 8'h05, 1, 0, 0);
    send(3'h2, 32'h0, 2'd2, 4'hF, 32'h5, 8'h06, 1, 0, 0);
    send(3'h4, 32'h0, 2'd3, 4'hF, 0, 8'h07, 1, 0, 0);
    send(3'h0, 32'h1, 2'd1, 4'h3, 32'h77, 8'h08, 1, 0, 0);
    send(3'h1, 32'hC, 2'd2, 4'b0000, 32'hFFFF_FFFF, 8'h09, 0, 32'h0, 0);
    send(3'h4, 32'hC, 2'd2, 4'hF, 0, 8'h0A, 0, 0, 32'hA000_0003);
    send(3'h4, 32'h6, 2'd1, 4'hC, 0, 8'h0B, 0, 0, 32'hA000_0001);
    send(3'h4, 32'h13, 2'd0, 4'h8, 0, 8'h0C, 0, 0, 32'hDEAD_BEEF);
    wait_drain();
    // backpressure: four accepts fill the device, D holds while stalled
    tl_i.d_ready = 1'b0;
    send(3'h4, 32'h0, 2'd2, 4'hF, 0, 8'h10, 0, 0, 32'hA000_0000);
    send(3'h4, 32'h4, 2'd2, 4'hF, 0, 8'h11, 0, 0, 32'hA000_0001);
    send(3'h4, 32'hC, 2'd2, 4'hF, 0, 8'h12, 0, 0, 32'hA000_0003);
    send(3'h4, 32'h14, 2'd2, 4'hF, 0, 8'h13, 0, 0, 32'hA000_0005);
    @(negedge clk_i);
    chk("s4_a_ready_full", 64'(tl_o.a_ready), 64'(0));
    chk("s4_d_valid", 64'(tl_o.d_valid), 64'(1));
    snap = 64'(tl_o);
    repeat (3) begin
      @(negedge clk_i);
      chk("s4_d_stable", 64'(tl_o), snap);
    end
    @(posedge clk_i);
    #1 tl_i.d_ready = 1'b1;
    @(negedge clk_i);
    chk("s4_a_ready_pre_hs", 64'(tl_o.a_ready), 64'(0));
    @(posedge clk_i);
    #1 tl_i.d_ready = 1'b0;
    @(negedge clk_i);
    chk("s4_a_ready_post_hs", 64'(tl_o.a_ready), 64'(1));
    @(posedge clk_i);
    #1 tl_i.d_ready = 1'b1;
    wait_drain();
    // streaming: one response per cycle in source order
    hs_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(3'h4, 32'((8 + i) * 4), 2'd2, 4'hF, 0, 8'(i), 0, 0, 32'hA000_0008 + 32'(i));
    w = 0;
    while (hs_cyc.size() < 8 && w < 50) begin
      w++;
      @(negedge clk_i);
    end
    chk("s5_rsp_count", 64'(hs_cyc.size()), 64'(8));
    if (hs_cyc.size() >= 8) chk("s5_rsp_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'(7));
    wait_drain();
    // reset with requests in flight: everything discarded
    tl_i.d_ready = 1'b0;
    send(3'h4, 32'h18, 2'd2, 4'hF, 0, 8'h20, 0, 0, 32'hA000_0006);
    send(3'h4, 32'h1C, 2'd2, 4'hF, 0, 8'h21, 0, 0, 32'hA000_0007);
    send(3'h4, 32'h24, 2'd2, 4'hF, 0, 8'h22, 0, 0, 32'hA000_0009);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    sb.delete();
    @(negedge clk_i);
    chk("s6_d_valid", 64'(tl_o.d_valid), 64'(0));
    chk("s6_a_ready", 64'(tl_o.a_ready), 64'(1));
    tl_i.d_ready = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      chk("s6_no_stale", 64'(tl_o.d_valid), 64'(0));
    end
    @(posedge clk_i);
    #1;
    send(3'h4, 32'h28, 2'd2, 4'hF, 0, 8'h30, 0, 0, 32'hA000_000A);
    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
